// File: rtl/mux_select_sequencer_pkg.sv
// Shared definitions for the mux select sequencer: state encodings,
// channel indices, the fixed index-to-select mapping and the default
// settle window.
package mux_select_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    localparam int DEFAULT_SETTLE_CYCLES = 2;

    // Returns {s1, s2} for a channel index.
    function automatic logic [1:0] sel_of(input logic [1:0] idx);
        logic [1:0] sel;
        case (idx)
            CH_A:    sel = 2'b00;
            CH_B:    sel = 2'b10;
            CH_C:    sel = 2'b01;
            default: sel = 2'b11;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mux_select_sequencer_if.sv
// Bus between the channel requesters / capture logic and the sequencer.
//
// Handshake: sel_valid rises once the select has been stable for the
// settle window and then stays high, with s1/s2/ch_idx frozen, until a
// rising edge samples ack=1. That edge completes exactly one transfer;
// sel_valid is low the next cycle. ack is ignored while sel_valid=0.
interface mux_select_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [3:0]       req;
    logic             ack;
    logic             s1;
    logic             s2;
    logic [1:0]       ch_idx;
    logic             sel_valid;
    logic             busy;
    logic [CNT_W-1:0] xfer_cnt;

    modport master (
        output en, req, ack,
        input  s1, s2, ch_idx, sel_valid, busy, xfer_cnt
    );

    modport slave (
        input  en, req, ack,
        output s1, s2, ch_idx, sel_valid, busy, xfer_cnt
    );

endinterface

// File: rtl/mux_select_sequencer_rr_pick4.sv
// Combinational round-robin picker for four requesters. The search
// starts at last+1 and wraps modulo 4; the first set request wins.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       any,
    output logic [1:0] win
);

    logic [1:0] idx;

    // Scan the four candidates in priority order starting after last.
    always_comb begin
        any = 1'b0;
        win = last;
        idx = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/mux_select_sequencer.sv
// Upstream control for the 4-bit 4-to-1 channel mux: grants one
// requesting channel round-robin, holds the select for a settle window,
// then presents it to the capture logic until acknowledged.
module mux_select_sequencer
    import mux_select_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int CNT_W         = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    mux_select_sequencer_if.slave        bus,
    output state_t                       state_dbg
);

    state_t           state;
    logic [3:0]       settle_cnt;
    logic [1:0]       last;
    logic [1:0]       ch_idx;
    logic             s1;
    logic             s2;
    logic             sel_valid;
    logic             busy;
    logic [CNT_W-1:0] xfer_cnt;

    logic             any;
    logic [1:0]       win;

    rr_pick4 u_pick (
        .req  (bus.req),
        .last (last),
        .any  (any),
        .win  (win)
    );

    // Grant / settle / present sequencing with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            last       <= CH_D;
            ch_idx     <= CH_A;
            s1         <= 1'b0;
            s2         <= 1'b0;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (bus.en && any) begin
                        ch_idx     <= win;
                        {s1, s2}   <= sel_of(win);
                        settle_cnt <= 4'(SETTLE_CYCLES - 1);
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!bus.en || !bus.req[ch_idx]) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (settle_cnt == 4'd0) begin
                        sel_valid <= 1'b1;
                        state     <= ST_PRESENT;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_PRESENT: begin
                    // Select is frozen here; only ack can end the presentation.
                    if (bus.ack) begin
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        last      <= ch_idx;
                        xfer_cnt  <= xfer_cnt + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s1        = s1;
    assign bus.s2        = s2;
    assign bus.ch_idx    = ch_idx;
    assign bus.sel_valid = sel_valid;
    assign bus.busy      = busy;
    assign bus.xfer_cnt  = xfer_cnt;
    assign state_dbg     = state;

endmodule

// File: doc/mux_select_sequencer.md
Name: mux_select_sequencer

Overview:
- Upstream control stage for the 4-bit 4-to-1 channel mux. Drives the mux select pair (s1, s2).
- Arbitrates round-robin among four requesting channels and holds the select stable for a settle window.
- Then presents a valid/ack handshake so the downstream capture logic samples the mux output exactly once per grant.

Parameters:
- SETTLE_CYCLES, default 2: cycles the select is held before sel_valid asserts. Legal range 1..15.
- CNT_W, default 8: width of the completed-transfer counter.

Ports:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  scan enable; no new grant starts while low.
- req  input  4  per-channel request; bit0=a, bit1=b, bit2=c, bit3=d.
- ack  input  1  downstream has captured the mux output; meaningful only while sel_valid=1.
- s1  output  1  mux select, registered.
- s2  output  1  mux select, registered.
- ch_idx  output  2  granted channel index 0..3, registered.
- sel_valid  output  1  mux output is settled and may be captured.
- busy  output  1  high in SETTLE or PRESENT.
- xfer_cnt  output  CNT_W  count of completed handshakes.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. The clock port is clk; the reset port is reset_n.
- Reset (immediate on reset_n=0, independent of clk):
  - s1=0, s2=0, ch_idx=0, sel_valid=0, busy=0, xfer_cnt=0.
  - State=IDLE; last-grant pointer=3, so the first search starts at channel 0.
- Select mapping (fixed):
  - ch0 (a): s1=0, s2=0.
  - ch1 (b): s1=1, s2=0.
  - ch2 (c): s1=0, s2=1.
  - ch3 (d): s1=1, s2=1.
- Round-robin:
  - Search order starts at last+1 and wraps modulo 4; the first set req bit wins.
  - The pointer updates only on a completed handshake.
- IDLE:
  - sel_valid=0, busy=0.
  - If en=1 and req!=0 at a rising edge: load ch_idx/s1/s2 for the winner, settle counter=SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise stay in IDLE; s1/s2/ch_idx hold their last value.
- SETTLE:
  - busy=1, sel_valid=0.
  - Each cycle: if en=0 or req[ch_idx]=0, abort to IDLE; pointer and xfer_cnt are unchanged.
  - Else if counter==0, go to PRESENT; else decrement.
  - The select is stable for exactly SETTLE_CYCLES cycles before sel_valid rises.
- PRESENT:
  - sel_valid=1, busy=1.
  - s1/s2/ch_idx are frozen; en and req changes are ignored, so the handshake is never withdrawn.
  - On ack=1: go to IDLE, pointer=ch_idx, xfer_cnt+1 (wraps from 2^CNT_W-1 to 0); sel_valid is 0 the following cycle.
- Latency: grant edge k → sel_valid high from edge k+SETTLE_CYCLES. Minimum grant-to-grant spacing is SETTLE_CYCLES+2 cycles (one IDLE bubble).
- ack while not in PRESENT: ignored.
- Simultaneous ack and req changes in PRESENT: the ack completes the handshake; the new req is evaluated in the IDLE cycle.
- Reset mid-operation (any state): immediate return to reset values; the in-flight grant is lost and not counted.
- State encoding: IDLE=2'd0, SETTLE=2'd1, PRESENT=2'd2. 2'd3 is illegal and recovers to IDLE with sel_valid=0.

Decomposition:
- Shared package holds:
  - State encodings.
  - Channel index constants CH_A..CH_D.
  - A function mapping a 2-bit index to {s1, s2}.
  - Default SETTLE_CYCLES.
- One combinational sub-module, rr_pick4 (inputs req[3:0], last[1:0]; outputs any, win[1:0]), instantiated once. All state lives in mux_select_sequencer.

Test Plan:
- reset_n=0 with all inputs random → s1=s2=sel_valid=busy=0, ch_idx=0, xfer_cnt=0 without any clk edge.
- SETTLE_CYCLES=2, en=1, req=4'b0100 → s1=0, s2=1, ch_idx=2 one edge after; sel_valid rises 2 edges later. Hold ack=1 one cycle → sel_valid=0 next cycle, xfer_cnt=1.
- req=4'b1111 held, ack pulsed on every sel_valid → ch_idx sequence 0,1,2,3,0; (s1,s2) = 00,10,01,11,00; xfer_cnt=5.
- Grant ch1, then drop req[1] during SETTLE → return to IDLE, sel_valid never asserts, xfer_cnt unchanged. With req=4'b1010, the next grant is ch1 again (pointer not advanced).
- In PRESENT, drive en=0 and req=0 for 5 cycles → sel_valid stays 1 and s1/s2 stay frozen. Then ack=1 → completes normally.
- CNT_W=8: 256 completed handshakes → xfer_cnt returns to 0. Assert reset_n=0 mid-PRESENT → sel_valid drops asynchronously and xfer_cnt=0.
